subcalc_serial: RTL and testbench

SUBCALC_SERIAL -- requirements
Module: subcalc_serial

---
 rtl/subcalc_serial.sv | 156 +++++++++++++++
 tb/tb_subcalc_serial.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/subcalc_serial.sv
// subcalc_serial: single-operand calculator with a bit-serial shift/rotate path.
// NOT, INC and DEC, and any shift/rotate with a zero step count, finish on the
// accepting edge. A shift/rotate with a non-zero count runs one single-bit step
// per clock in a private working register. OUTPUT/FLAG change only on completion.
//
// Ports
//   CLK     in   1      single clock, rising edge
//   RESET   in   1      asynchronous, active-high reset
//   START   in   1      operation request, sampled only while idle
//   INPUT   in   WIDTH  operand, captured on the accepting edge
//   KIND    in   3      operation select, captured on the accepting edge
//   AMOUNT  in   CNTW   step count for shift/rotate kinds
//   BUSY    out  1      multi-cycle operation in progress
//   DONE    out  1      one-cycle pulse, result valid
//   OUTPUT  out  WIDTH  registered result
//   FLAG    out  1      registered flag
//
// State | meaning
// IDLE  | waiting for START; single-cycle operations complete here
// STEP  | one shift/rotate step per clock until the step counter expires
module subcalc_serial #(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] INPUT,
    input  logic [2:0]       KIND,
    input  logic [CNTW-1:0]  AMOUNT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] OUTPUT,
    output logic             FLAG
);

    localparam logic [2:0] K_NOT = 3'b000;
    localparam logic [2:0] K_SRL = 3'b001;
    localparam logic [2:0] K_INC = 3'b010;
    localparam logic [2:0] K_DEC = 3'b011;
    localparam logic [2:0] K_SLL = 3'b100;
    localparam logic [2:0] K_SRA = 3'b101;
    localparam logic [2:0] K_ROR = 3'b110;
    localparam logic [2:0] K_ROL = 3'b111;

    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [CNTW-1:0]  ONE_C   = CNTW'(1);

    typedef enum logic {IDLE, STEP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [CNTW-1:0]  cnt, cnt_nxt;
    logic [2:0]       kind_q, kind_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             flag_nxt;
    logic             done_nxt;
    logic [WIDTH:0]   step_res;
    logic [WIDTH:0]   inc_sum;
    logic             start_is_shift;

    // One single-bit step; result is {flag, value}.
    function automatic logic [WIDTH:0] step_once(input logic [2:0] k, input logic [WIDTH-1:0] v);
        case (k)
            K_SRL:   step_once = {v[0], 1'b0, v[WIDTH-1:1]};
            K_SRA:   step_once = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            K_ROR:   step_once = {v[0], v[0], v[WIDTH-1:1]};
            K_SLL:   step_once = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            K_ROL:   step_once = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            default: step_once = {1'b0, v};
        endcase
    endfunction

    assign BUSY           = (state == STEP);
    assign step_res       = step_once(kind_q, work);
    assign inc_sum        = {1'b0, INPUT} + {1'b0, ONE_W};
    assign start_is_shift = KIND[2] | (KIND == K_SRL);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            kind_q <= K_NOT;
            OUTPUT <= '0;
            FLAG   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_nxt;
            work   <= work_nxt;
            cnt    <= cnt_nxt;
            kind_q <= kind_nxt;
            OUTPUT <= result_nxt;
            FLAG   <= flag_nxt;
            DONE   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        work_nxt   = work;
        cnt_nxt    = cnt;
        kind_nxt   = kind_q;
        result_nxt = OUTPUT;
        flag_nxt   = FLAG;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    kind_nxt = KIND;
                    if (start_is_shift) begin
                        if (AMOUNT == '0) begin
                            result_nxt = INPUT;
                            flag_nxt   = 1'b0;
                            done_nxt   = 1'b1;
                        end else begin
                            work_nxt  = INPUT;
                            cnt_nxt   = AMOUNT;
                            state_nxt = STEP;
                        end
                    end else begin
                        done_nxt = 1'b1;
                        case (KIND)
                            K_INC: begin
                                result_nxt = inc_sum[WIDTH-1:0];
                                flag_nxt   = inc_sum[WIDTH];
                            end
                            K_DEC: begin
                                result_nxt = INPUT - ONE_W;
                                flag_nxt   = (INPUT != '0);
                            end
                            default: begin
                                result_nxt = ~INPUT;
                                flag_nxt   = 1'b1;
                            end
                        endcase
                    end
                end
            end
            STEP: begin
                work_nxt = step_res[WIDTH-1:0];
                cnt_nxt  = cnt - ONE_C;
                // Last step: publish straight from the step result so the
                // final value appears together with DONE.
                if (cnt == ONE_C) begin
                    result_nxt = step_res[WIDTH-1:0];
                    flag_nxt   = step_res[WIDTH];
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_subcalc_serial.sv
// Testbench for subcalc_serial (WIDTH = 4): directed operations checked by
// hand-computed literals, plus a cycle model compared on every falling edge.
module tb_subcalc_serial;

    localparam int W  = 4;
    localparam int CW = $clog2(W) + 1;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  din   = '0;
    logic [2:0]    kind  = '0;
    logic [CW-1:0] amt   = '0;
    logic          busy, done, flag;
    logic [W-1:0]  dout;

    int checks = 0;
    int errors = 0;

    subcalc_serial #(.WIDTH(W)) dut (
        .CLK(clk), .RESET(rst), .START(start), .INPUT(din), .KIND(kind),
        .AMOUNT(amt), .BUSY(busy), .DONE(done), .OUTPUT(dout), .FLAG(flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation result from plain arithmetic on the operand.
    function automatic void model(input int k, input int v, input int n, output int r, output int f);
        int m;
        int s;
        int rr;
        m  = (1 << W) - 1;
        s  = (v >= (1 << (W - 1))) ? v - (1 << W) : v;
        rr = n % W;
        r  = v;
        f  = 0;
        case (k)
            0: begin r = ~v & m; f = 1; end
            2: begin r = (v + 1) & m; f = (v == m) ? 1 : 0; end
            3: begin r = (v - 1) & m; f = (v != 0) ? 1 : 0; end
            1: begin
                r = (n >= W) ? 0 : (v >> n);
                f = (n == 0 || n > W) ? 0 : (v >> (n - 1)) & 1;
            end
            4: begin
                r = (n >= W) ? 0 : (v << n) & m;
                f = (n == 0 || n > W) ? 0 : (v >> (W - n)) & 1;
            end
            5: begin
                r = (s >>> n) & m;
                f = (n == 0) ? 0 : (s >>> (n - 1)) & 1;
            end
            6: begin
                r = ((v >> rr) | (v << (W - rr))) & m;
                f = (n == 0) ? 0 : (r >> (W - 1)) & 1;
            end
            default: begin
                r = ((v << rr) | (v >> (W - rr))) & m;
                f = (n == 0) ? 0 : r & 1;
            end
        endcase
    endfunction

    // Cycle model: an accepted multi-step operation owes its result n edges later.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_flag = 1'b0;
    logic [W-1:0] m_out  = '0;
    int rem    = 0;
    int p_out  = 0;
    int p_flag = 0;

    always @(posedge clk or posedge rst) begin
        int r, f;
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_out  <= '0;
            m_flag <= 1'b0;
            rem = 0;
        end else begin
            m_done <= 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_out  <= W'(p_out);
                    m_flag <= p_flag[0];
                end
            end else if (start) begin
                model(int'(kind), int'(din), int'(amt), r, f);
                if (kind inside {3'b001, 3'b100, 3'b101, 3'b110, 3'b111} && amt != '0) begin
                    rem    = int'(amt);
                    p_out  = r;
                    p_flag = f;
                    m_busy <= 1'b1;
                end else begin
                    m_out  <= W'(r);
                    m_flag <= f[0];
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", int'(busy), int'(m_busy));
        chk("cyc_done", int'(done), int'(m_done));
        chk("cyc_out",  int'(dout), int'(m_out));
        chk("cyc_flag", int'(flag), int'(m_flag));
    end

    // Called at a falling edge; returns at the falling edge where DONE is seen,
    // so a following call starts in the DONE cycle.
    task automatic run_op(input string name, input logic [2:0] k, input logic [W-1:0] a,
                          input int n, input logic [W-1:0] eo, input int ef,
                          input int elat, input int ebusy, input int glitch);
        int lat  = 0;
        int bcnt = 0;
        int seen = 0;
        start = 1'b1;
        kind  = k;
        din   = a;
        amt   = CW'(n);
        while (seen == 0 && lat < 40) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            din   = ~a;
            if (glitch != 0 && lat == glitch) begin
                start = 1'b1;
                kind  = 3'b010;
                din   = 4'b1111;
                amt   = '0;
            end
            if (busy) bcnt++;
            if (done) seen = 1;
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_latency"}, lat, elat);
        chk({name, "_busy_cycles"}, bcnt, ebusy);
        chk({name, "_out"}, int'(dout), int'(eo));
        chk({name, "_flag"}, int'(flag), ef);
    endtask

    initial begin
        int ndone;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_out",  int'(dout), 0);
        chk("reset_flag", int'(flag), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("inc_1111",   3'b010, 4'b1111, 0, 4'b0000, 1, 1, 0, 0);
        run_op("dec_0000",   3'b011, 4'b0000, 0, 4'b1111, 0, 1, 0, 0);
        run_op("dec_0101",   3'b011, 4'b0101, 0, 4'b0100, 1, 1, 0, 0);
        run_op("srl_1011_1", 3'b001, 4'b1011, 1, 4'b0101, 1, 2, 1, 0);
        run_op("rol_1001_3", 3'b111, 4'b1001, 3, 4'b1100, 0, 4, 3, 0);
        run_op("sra_1000_2", 3'b101, 4'b1000, 2, 4'b1110, 0, 3, 2, 0);
        run_op("sll_0001_0", 3'b100, 4'b0001, 0, 4'b0001, 0, 1, 0, 0);
        run_op("ror_0110_5", 3'b110, 4'b0110, 5, 4'b0011, 0, 6, 5, 2);
        run_op("not_1010",   3'b000, 4'b1010, 0, 4'b0101, 1, 1, 0, 0);
        run_op("srl_1000_7", 3'b001, 4'b1000, 7, 4'b0000, 0, 8, 7, 0);
        run_op("sll_0110_3", 3'b100, 4'b0110, 3, 4'b0000, 1, 4, 3, 0);
        run_op("rol_1000_4", 3'b111, 4'b1000, 4, 4'b1000, 0, 5, 4, 0);
        run_op("sra_1010_6", 3'b101, 4'b1010, 6, 4'b1111, 1, 7, 6, 0);

        // Reset in the middle of a 4-step SRL.
        start = 1'b1;
        kind  = 3'b001;
        din   = 4'b1111;
        amt   = CW'(4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_out",  int'(dout), 4'b1111);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_out",  int'(dout), 0);
        chk("rst_flag", int'(flag), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_done_after_rst", ndone, 0);
        run_op("inc_0010", 3'b010, 4'b0010, 0, 4'b0011, 0, 1, 0, 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
